// File: rtl/ppe_pkg.sv
// Shared definitions for programmable-priority-encoder clients: scheduler state
// encoding, default widths, and a one-hot to binary index encoder.
package ppe_pkg;

  localparam int PPE_WIDTH_DFLT = 1024;
  localparam int PPE_LOG_W_DFLT = 10;

  // Widest vector the shared encoder handles; narrower clients zero-extend.
  localparam int PPE_MAX_W     = 1024;
  localparam int PPE_MAX_LOG_W = 10;

  localparam logic [0:0] SCHED_IDLE  = 1'b0;
  localparam logic [0:0] SCHED_OFFER = 1'b1;

  // OR-reduction encode: correct for one-hot or all-zero inputs.
  function automatic logic [PPE_MAX_LOG_W-1:0] onehot_to_idx(
    input logic [PPE_MAX_W-1:0] onehot
  );
    logic [PPE_MAX_LOG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < PPE_MAX_W; i++) begin
      if (onehot[i]) idx = idx | PPE_MAX_LOG_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ppe.sv
// Programmable priority encoder: one-hot grant of the lowest set req bit at index
// >= p_enc, wrapping to the lowest set bit overall when none exists above p_enc.
module ppe
  import ppe_pkg::*;
#(
  parameter int PPE_WIDTH = PPE_WIDTH_DFLT,
  parameter int PPE_LOG_W = PPE_LOG_W_DFLT
) (
  input  logic [PPE_LOG_W-1:0] p_enc,
  input  logic [PPE_WIDTH-1:0] req,
  output logic [PPE_WIDTH-1:0] gnt,
  output logic                 valid
);

  logic [PPE_WIDTH-1:0] mask;
  logic [PPE_WIDTH-1:0] req_hi;
  logic [PPE_WIDTH-1:0] pick;

  always_comb begin
    mask   = {PPE_WIDTH{1'b1}} << p_enc;
    req_hi = req & mask;
    // Prefer requesters at or above the pointer; otherwise wrap to the full set.
    pick   = (|req_hi) ? req_hi : req;
    gnt    = pick & (~pick + PPE_WIDTH'(1));
    valid  = |req;
  end

endmodule

// File: rtl/ppe_rr_sched.sv
// Registered round-robin scheduler around one ppe instance with a valid/ready grant.
// Define PPE_SCHED_LOCK_EN to keep the grant across a burst until req_last.
module ppe_rr_sched
  import ppe_pkg::*;
#(
  parameter int PPE_WIDTH = PPE_WIDTH_DFLT,
  parameter int PPE_LOG_W = PPE_LOG_W_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PPE_WIDTH-1:0] req,
  input  logic                 gnt_ready,
  input  logic                 req_last,
  output logic [PPE_WIDTH-1:0] gnt,
  output logic [PPE_LOG_W-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic [PPE_LOG_W-1:0] ptr
);

  // Handshake: a beat transfers when gnt_valid & gnt_ready; gnt/gnt_idx/ptr hold
  // while gnt_valid is high until a transferring beat also releases ownership.

  logic [PPE_WIDTH-1:0] gnt_q,     gnt_d;
  logic [PPE_LOG_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [PPE_LOG_W-1:0] ptr_q,     ptr_d;
  logic [0:0]           state_q,   state_d;

  logic [PPE_WIDTH-1:0] ppe_gnt;
  logic                 ppe_valid;
  logic [PPE_LOG_W-1:0] gnt_idx_new;
  logic                 rel;
  logic                 load;

  ppe #(
    .PPE_WIDTH (PPE_WIDTH),
    .PPE_LOG_W (PPE_LOG_W)
  ) u_ppe (
    .p_enc (ptr_q),
    .req   (req),
    .gnt   (ppe_gnt),
    .valid (ppe_valid)
  );

`ifdef PPE_SCHED_LOCK_EN
  assign rel = req_last;
`else
  logic req_last_unused;
  assign req_last_unused = req_last;
  assign rel = 1'b1;
`endif

  assign gnt_idx_new = PPE_LOG_W'(onehot_to_idx(PPE_MAX_W'(ppe_gnt)));

  always_comb begin
    load      = (state_q == SCHED_IDLE) |
                ((state_q == SCHED_OFFER) & gnt_ready & rel);
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    state_d   = state_q;
    if (load) begin
      if (ppe_valid) begin
        gnt_d     = ppe_gnt;
        gnt_idx_d = gnt_idx_new;
        // Power-of-two width makes the +1 wrap to zero naturally.
        ptr_d     = gnt_idx_new + PPE_LOG_W'(1);
        state_d   = SCHED_OFFER;
      end else begin
        gnt_d   = '0;
        state_d = SCHED_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      state_q   <= SCHED_IDLE;
    end else begin
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      state_q   <= state_d;
    end
  end

  // The OFFER state is exactly the grant-valid condition, so it doubles as state visibility.
  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == SCHED_OFFER);
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_ppe_rr_sched.sv
// Self-checking bench for ppe_rr_sched at PPE_WIDTH=8; adapts burst expectations
// to whether PPE_SCHED_LOCK_EN is defined.
module tb_ppe_rr_sched;

  localparam int W  = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req;
  logic          gnt_ready;
  logic          req_last;
  logic [W-1:0]  gnt;
  logic [LW-1:0] gnt_idx;
  logic          gnt_valid;
  logic [LW-1:0] ptr;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  ppe_rr_sched #(
    .PPE_WIDTH (W),
    .PPE_LOG_W (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ready (gnt_ready),
    .req_last  (req_last),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    gnt_ready = 1'b0;
    req_last  = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  // Rotating search from p: first set bit at p, p+1, ... modulo W.
  function automatic int ref_pick(input logic [W-1:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      if (r[(p + k) % W]) return (p + k) % W;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '0; gnt_ready = 1'b0; req_last = 1'b0;
    #3;
    checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got %h want 00", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", gnt_valid); end
    checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", ptr); end
    checks++; if (gnt_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", gnt_idx); end
    rst = 1'b0; req = 8'h04;
    tick();
    checks++; if (gnt !== 8'h04 || gnt_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_offer got %h/%b want 04/1", gnt, gnt_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || ptr !== 3'd0) begin
      errors++; $display("FAIL async_rst got gnt %h valid %b ptr %0d want 00/0/0", gnt, gnt_valid, ptr);
    end
    req = 8'h10; rst = 1'b0;
    tick();
    checks++; if (gnt !== 8'h10 || gnt_idx !== 3'd4 || gnt_valid !== 1'b1) begin
      errors++; $display("FAIL post_rst_grant got %h idx %0d want 10 idx 4", gnt, gnt_idx);
    end
  endtask

  task automatic test_all_req();
    do_reset();
    req = 8'hFF; gnt_ready = 1'b1; req_last = 1'b1;
    for (int i = 0; i <= W; i++) exp_q.push_back(W'(1) << (i % W));
    for (int i = 0; i <= W; i++) begin
      logic [W-1:0] e;
      tick();
      e = exp_q.pop_front();
      checks++; if (gnt !== e || gnt_valid !== 1'b1) begin
        errors++; $display("FAIL fair_seq[%0d] got %h valid %b want %h", i, gnt, gnt_valid, e);
      end
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h20;
    tick();
    checks++; if (gnt !== 8'h20 || ptr !== 3'd6) begin errors++; $display("FAIL wrap_setup got %h ptr %0d want 20 ptr 6", gnt, ptr); end
    req = 8'h05; gnt_ready = 1'b1; req_last = 1'b1;
    tick();
    checks++; if (gnt !== 8'h01 || ptr !== 3'd1) begin errors++; $display("FAIL wrap_grant got %h ptr %0d want 01 ptr 1", gnt, ptr); end
    tick();
    checks++; if (gnt !== 8'h04 || ptr !== 3'd3 || gnt_idx !== 3'd2) begin
      errors++; $display("FAIL wrap_next got %h ptr %0d idx %0d want 04 ptr 3 idx 2", gnt, ptr, gnt_idx);
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    req = 8'h02;
    tick();
    req = 8'h80;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (gnt !== 8'h02 || ptr !== 3'd2 || gnt_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got %h ptr %0d want 02 ptr 2", i, gnt, ptr);
      end
    end
    gnt_ready = 1'b1; req_last = 1'b1;
    tick();
    checks++; if (gnt !== 8'h80 || gnt_idx !== 3'd7 || ptr !== 3'd0) begin
      errors++; $display("FAIL stall_release got %h idx %0d ptr %0d want 80 idx 7 ptr 0", gnt, gnt_idx, ptr);
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    req = 8'h02; gnt_ready = 1'b1; req_last = 1'b1;
    tick();
    req = 8'h00;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (gnt_valid !== 1'b0 || gnt !== 8'h00 || ptr !== 3'd2) begin
        errors++; $display("FAIL idle_hold[%0d] got valid %b gnt %h ptr %0d want 0/00/2", i, gnt_valid, gnt, ptr);
      end
    end
    gnt_ready = 1'b0; req = 8'h08;
    tick();
    req = 8'h00;
    checks++; if (gnt_valid !== 1'b1 || gnt !== 8'h08 || ptr !== 3'd4) begin
      errors++; $display("FAIL idle_wake got valid %b gnt %h ptr %0d want 1/08/4", gnt_valid, gnt, ptr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (gnt_valid !== 1'b1 || gnt !== 8'h08) begin
        errors++; $display("FAIL idle_keep[%0d] got valid %b gnt %h want 1/08", i, gnt_valid, gnt);
      end
    end
    gnt_ready = 1'b1;
    tick();
    checks++; if (gnt_valid !== 1'b0 || gnt !== 8'h00 || ptr !== 3'd4) begin
      errors++; $display("FAIL idle_drain got valid %b gnt %h ptr %0d want 0/00/4", gnt_valid, gnt, ptr);
    end
    gnt_ready = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    req = 8'h03;
    tick();
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL lock_owner got %h want 01", gnt); end
    gnt_ready = 1'b1; req_last = 1'b0;
    tick();
`ifdef PPE_SCHED_LOCK_EN
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL lock_beat0 got %h want 01", gnt); end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL lock_beat%0d got %h want 01", i, gnt); end
    end
    gnt_ready = 1'b0; req_last = 1'b1;
    tick();
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL lock_noready got %h want 01", gnt); end
    gnt_ready = 1'b1;
    tick();
    checks++; if (gnt !== 8'h02) begin errors++; $display("FAIL lock_release got %h want 02", gnt); end
`else
    checks++; if (gnt !== 8'h02) begin errors++; $display("FAIL nolock_move got %h want 02", gnt); end
`endif
    gnt_ready = 1'b0;
  endtask

  task automatic test_random();
    logic          mv;
    int            mptr;
    int            p;
    logic [W-1:0]  mgnt;
    do_reset();
    mv = 1'b0; mptr = 0; mgnt = '0;
    req_last = 1'b1;
    for (int c = 0; c < 300; c++) begin
      logic [W-1:0] e;
      req       = ($urandom_range(0, 3) == 0) ? 8'h00 : W'($urandom_range(0, 255));
      gnt_ready = 1'($urandom_range(0, 1));
      if (!mv || gnt_ready) begin
        p = ref_pick(req, mptr);
        if (p >= 0) begin
          mv = 1'b1; mgnt = W'(1) << p; mptr = (p + 1) % W;
        end else begin
          mv = 1'b0; mgnt = '0;
        end
      end
      exp_q.push_back(mgnt);
      tick();
      e = exp_q.pop_front();
      checks++; if (gnt !== e || gnt_valid !== mv || ptr !== LW'(mptr)) begin
        errors++; $display("FAIL rand[%0d] got gnt %h valid %b ptr %0d want %h/%b/%0d", c, gnt, gnt_valid, ptr, e, mv, mptr);
      end
    end
    gnt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_req();
    test_wrap();
    test_stall();
    test_idle();
    test_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
